// File: rtl/ball_renderer.sv
// Ball square renderer: accepts positions over valid/ready, erases the previous
// square to background, then paints the new one, one pixel per clock.
module ball_renderer #(
  parameter int unsigned BALL_SIZE   = 4,
  parameter int unsigned X_MAX       = 160,
  parameter int unsigned Y_MAX       = 120,
  parameter logic [2:0]  BG_COLOUR   = 3'b000,
  parameter logic [2:0]  BALL_COLOUR = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic       pos_valid,
  output logic       pos_ready,
  input  logic       clear,
  output logic [9:0] plot_x,
  output logic [9:0] plot_y,
  output logic [2:0] plot_colour,
  output logic       plot_en,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StErase, StDraw, StClr} state_e;

  localparam logic [2:0] Last = 3'(BALL_SIZE - 1);

  state_e     state_q, state_d;
  logic [2:0] dx_q, dx_d, dy_q, dy_d;
  logic [9:0] new_x_q, new_x_d, new_y_q, new_y_d;
  logic [9:0] old_x_q, old_x_d, old_y_q, old_y_d;
  logic       have_old_q, have_old_d;

  // Pixel loaded into the output registers on the next edge
  logic        px_load;
  logic [9:0]  px_base_x, px_base_y;
  logic [2:0]  px_colour;
  logic [10:0] px_sum_x, px_sum_y;
  logic        last_px;

  assign last_px   = (dx_q == Last) && (dy_q == Last);
  assign pos_ready = (state_q == StIdle) && !clear;
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    new_x_d    = new_x_q;
    new_y_d    = new_y_q;
    old_x_d    = old_x_q;
    old_y_d    = old_y_q;
    have_old_d = have_old_q;
    px_load    = 1'b0;
    px_base_x  = old_x_q;
    px_base_y  = old_y_q;
    px_colour  = BG_COLOUR;

    unique case (state_q)
      StIdle: begin
        dx_d = '0;
        dy_d = '0;
        if (clear) begin
          if (have_old_q) begin
            state_d = StClr;
            px_load = 1'b1;
          end
        end else if (pos_valid) begin
          new_x_d = pos_x;
          new_y_d = pos_y;
          px_load = 1'b1;
          if (have_old_q && ((old_x_q != pos_x) || (old_y_q != pos_y))) begin
            state_d = StErase;
          end else begin
            state_d   = StDraw;
            px_base_x = pos_x;
            px_base_y = pos_y;
            px_colour = BALL_COLOUR;
          end
        end
      end
      StErase, StDraw, StClr: begin
        if (state_q == StDraw) begin
          px_base_x = new_x_q;
          px_base_y = new_y_q;
          px_colour = BALL_COLOUR;
        end
        if (!last_px) begin
          px_load = 1'b1;
          if (dx_q == Last) begin
            dx_d = '0;
            dy_d = dy_q + 3'd1;
          end else begin
            dx_d = dx_q + 3'd1;
          end
        end else begin
          dx_d = '0;
          dy_d = '0;
          unique case (state_q)
            StErase: begin
              state_d   = StDraw;
              px_load   = 1'b1;
              px_base_x = new_x_q;
              px_base_y = new_y_q;
              px_colour = BALL_COLOUR;
            end
            StDraw: begin
              state_d    = StIdle;
              old_x_d    = new_x_q;
              old_y_d    = new_y_q;
              have_old_d = 1'b1;
            end
            default: begin
              state_d    = StIdle;
              have_old_d = 1'b0;
            end
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // 11-bit sums so pixels past 1023 are clipped rather than wrapped
  assign px_sum_x = {1'b0, px_base_x} + {8'b0, dx_d};
  assign px_sum_y = {1'b0, px_base_y} + {8'b0, dy_d};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      dx_q        <= '0;
      dy_q        <= '0;
      new_x_q     <= '0;
      new_y_q     <= '0;
      old_x_q     <= '0;
      old_y_q     <= '0;
      have_old_q  <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= BG_COLOUR;
      plot_en     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      new_x_q    <= new_x_d;
      new_y_q    <= new_y_d;
      old_x_q    <= old_x_d;
      old_y_q    <= old_y_d;
      have_old_q <= have_old_d;
      if (px_load) begin
        plot_x      <= px_sum_x[9:0];
        plot_y      <= px_sum_y[9:0];
        plot_colour <= px_colour;
        plot_en     <= (px_sum_x < 11'(X_MAX)) && (px_sum_y < 11'(Y_MAX));
      end else begin
        plot_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ball_renderer.sv
// Directed bench for ball_renderer: draw, erase+draw, same position, clipping,
// clear, reset mid-frame and back-to-back acceptance.
module tb_ball_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pos_x, pos_y;
  logic       pos_valid, pos_ready, clear;
  logic [9:0] plot_x, plot_y;
  logic [2:0] plot_colour;
  logic       plot_en, busy;

  int checks = 0;
  int failures = 0;

  logic [9:0] cx[64];
  logic [9:0] cy[64];
  logic [2:0] cc[64];
  logic       ce[64];
  logic       cr[64];
  logic       cb[64];

  ball_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_valid  (pos_valid),
    .pos_ready  (pos_ready),
    .clear      (clear),
    .plot_x     (plot_x),
    .plot_y     (plot_y),
    .plot_colour(plot_colour),
    .plot_en    (plot_en),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Records outputs at n consecutive falling edges, starting with the current one
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cx[i] = plot_x;
      cy[i] = plot_y;
      cc[i] = plot_colour;
      ce[i] = plot_en;
      cr[i] = pos_ready;
      cb[i] = busy;
      @(negedge clk);
    end
  endtask

  // Offers one position for a single cycle; returns at the falling edge of cycle 1
  task automatic offer(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    pos_x = x;
    pos_y = y;
    pos_valid = 1'b1;
    @(negedge clk);
    pos_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pos_x = '0;
    pos_y = '0;
    pos_valid = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (plot_x !== 10'd0 || plot_y !== 10'd0 || plot_colour !== 3'b000 || plot_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_plot: got x=%0d y=%0d c=%b en=%b, want 0 0 000 0",
               plot_x, plot_y, plot_colour, plot_en);
    end
    checks++;
    if (busy !== 1'b0 || pos_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_hs: got busy=%b ready=%b, want 0 1", busy, pos_ready);
    end
  endtask

  task automatic test_first_draw();
    int n_en;
    offer(10'd10, 10'd20);
    capture(16);
    n_en = 0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cx[i] !== 10'(10 + i % 4) || cy[i] !== 10'(20 + i / 4) || cc[i] !== 3'b111 ||
          ce[i] !== 1'b1 || cr[i] !== 1'b0 || cb[i] !== 1'b1) begin
        failures++;
        $display("FAIL first_draw[%0d]: got (%0d,%0d) c=%b en=%b rdy=%b busy=%b, want (%0d,%0d) 111 1 0 1",
                 i, cx[i], cy[i], cc[i], ce[i], cr[i], cb[i], 10 + i % 4, 20 + i / 4);
      end
      if (ce[i]) n_en++;
    end
    checks++;
    if (pos_ready !== 1'b1 || plot_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL first_draw_end: got rdy=%b en=%b busy=%b, want 1 0 0", pos_ready, plot_en, busy);
    end
    checks++;
    if (n_en != 16) begin
      failures++;
      $display("FAIL first_draw_count: got %0d writes, want 16", n_en);
    end
  endtask

  task automatic test_erase_draw();
    int n_en;
    offer(10'd11, 10'd21);
    capture(32);
    n_en = 0;
    for (int i = 0; i < 32; i++) begin
      logic [9:0] ex, ey;
      logic [2:0] ec;
      if (i < 16) begin
        ex = 10'(10 + i % 4); ey = 10'(20 + i / 4); ec = 3'b000;
      end else begin
        ex = 10'(11 + (i - 16) % 4); ey = 10'(21 + (i - 16) / 4); ec = 3'b111;
      end
      checks++;
      if (cx[i] !== ex || cy[i] !== ey || cc[i] !== ec || ce[i] !== 1'b1 || cr[i] !== 1'b0) begin
        failures++;
        $display("FAIL erase_draw[%0d]: got (%0d,%0d) c=%b en=%b rdy=%b, want (%0d,%0d) %b 1 0",
                 i, cx[i], cy[i], cc[i], ce[i], cr[i], ex, ey, ec);
      end
      if (ce[i]) n_en++;
    end
    checks++;
    if (n_en != 32 || pos_ready !== 1'b1 || plot_en !== 1'b0) begin
      failures++;
      $display("FAIL erase_draw_end: got writes=%0d rdy=%b en=%b, want 32 1 0",
               n_en, pos_ready, plot_en);
    end
  endtask

  task automatic test_same_pos();
    offer(10'd11, 10'd21);
    capture(16);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cx[i] !== 10'(11 + i % 4) || cy[i] !== 10'(21 + i / 4) || cc[i] !== 3'b111 ||
          ce[i] !== 1'b1) begin
        failures++;
        $display("FAIL same_pos[%0d]: got (%0d,%0d) c=%b en=%b, want (%0d,%0d) 111 1",
                 i, cx[i], cy[i], cc[i], ce[i], 11 + i % 4, 21 + i / 4);
      end
    end
    checks++;
    if (pos_ready !== 1'b1 || plot_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL same_pos_end: got rdy=%b en=%b busy=%b, want 1 0 0", pos_ready, plot_en, busy);
    end
  endtask

  task automatic test_clip();
    int n_en;
    offer(10'd158, 10'd118);
    capture(32);
    n_en = 0;
    for (int j = 0; j < 16; j++) begin
      logic [9:0] ex, ey;
      logic       een;
      ex = 10'(158 + j % 4);
      ey = 10'(118 + j / 4);
      een = (ex < 10'd160) && (ey < 10'd120);
      checks++;
      if (cx[16 + j] !== ex || cy[16 + j] !== ey || cc[16 + j] !== 3'b111 || ce[16 + j] !== een) begin
        failures++;
        $display("FAIL clip[%0d]: got (%0d,%0d) c=%b en=%b, want (%0d,%0d) 111 %b",
                 j, cx[16 + j], cy[16 + j], cc[16 + j], ce[16 + j], ex, ey, een);
      end
      if (ce[16 + j]) n_en++;
    end
    checks++;
    if (n_en != 4 || cr[31] !== 1'b0 || pos_ready !== 1'b1) begin
      failures++;
      $display("FAIL clip_end: got writes=%0d rdy_last=%b rdy=%b, want 4 0 1", n_en, cr[31], pos_ready);
    end
  endtask

  task automatic test_clear();
    int n_en;
    offer(10'd11, 10'd21);
    capture(32);
    n_en = 0;
    for (int i = 0; i < 32; i++) if (ce[i]) n_en++;
    checks++;
    if (n_en != 20) begin
      failures++;
      $display("FAIL clear_setup: got writes=%0d, want 20", n_en);
    end
    @(negedge clk);
    clear = 1'b1;
    pos_valid = 1'b1;
    pos_x = 10'd50;
    pos_y = 10'd50;
    #1;
    checks++;
    if (pos_ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_ready: got rdy=%b, want 0", pos_ready);
    end
    @(negedge clk);
    clear = 1'b0;
    pos_valid = 1'b0;
    capture(16);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cx[i] !== 10'(11 + i % 4) || cy[i] !== 10'(21 + i / 4) || cc[i] !== 3'b000 ||
          ce[i] !== 1'b1 || cb[i] !== 1'b1) begin
        failures++;
        $display("FAIL clear_erase[%0d]: got (%0d,%0d) c=%b en=%b busy=%b, want (%0d,%0d) 000 1 1",
                 i, cx[i], cy[i], cc[i], ce[i], cb[i], 11 + i % 4, 21 + i / 4);
      end
    end
    checks++;
    if (pos_ready !== 1'b1 || plot_en !== 1'b0) begin
      failures++;
      $display("FAIL clear_end: got rdy=%b en=%b, want 1 0", pos_ready, plot_en);
    end
    offer(10'd30, 10'd40);
    capture(16);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cx[i] !== 10'(30 + i % 4) || cy[i] !== 10'(40 + i / 4) || cc[i] !== 3'b111) begin
        failures++;
        $display("FAIL clear_next_draw[%0d]: got (%0d,%0d) c=%b, want (%0d,%0d) 111",
                 i, cx[i], cy[i], cc[i], 30 + i % 4, 40 + i / 4);
      end
    end
    checks++;
    if (pos_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_next_end: got rdy=%b, want 1", pos_ready);
    end
  endtask

  task automatic test_reset_mid();
    offer(10'd0, 10'd0);
    capture(4);
    checks++;
    if (cc[0] !== 3'b000 || cx[0] !== 10'd30 || cy[0] !== 10'd40 || plot_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_erase: got (%0d,%0d) c=%b en=%b, want (30,40) 000 1",
               cx[0], cy[0], cc[0], plot_en);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (plot_en !== 1'b0 || pos_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got en=%b rdy=%b busy=%b, want 0 1 0", plot_en, pos_ready, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    offer(10'd5, 10'd6);
    capture(16);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cx[i] !== 10'(5 + i % 4) || cy[i] !== 10'(6 + i / 4) || cc[i] !== 3'b111 ||
          ce[i] !== 1'b1) begin
        failures++;
        $display("FAIL reset_mid_draw[%0d]: got (%0d,%0d) c=%b en=%b, want (%0d,%0d) 111 1",
                 i, cx[i], cy[i], cc[i], ce[i], 5 + i % 4, 6 + i / 4);
      end
    end
    checks++;
    if (pos_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_end: got rdy=%b busy=%b, want 1 0", pos_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    pos_x = 10'd60;
    pos_y = 10'd60;
    pos_valid = 1'b1;
    @(negedge clk);
    pos_x = 10'd61;
    capture(32);
    checks++;
    if (cx[0] !== 10'd5 || cy[0] !== 10'd6 || cc[0] !== 3'b000 ||
        cx[16] !== 10'd60 || cy[16] !== 10'd60 || cc[16] !== 3'b111) begin
      failures++;
      $display("FAIL b2b_first: got e(%0d,%0d)%b d(%0d,%0d)%b, want e(5,6)000 d(60,60)111",
               cx[0], cy[0], cc[0], cx[16], cy[16], cc[16]);
    end
    // Single IDLE cycle: valid still high, so acceptance happens on this edge
    checks++;
    if (pos_ready !== 1'b1 || plot_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got rdy=%b en=%b busy=%b, want 1 0 0", pos_ready, plot_en, busy);
    end
    @(negedge clk);
    pos_valid = 1'b0;
    capture(32);
    checks++;
    if (cx[0] !== 10'd60 || cy[0] !== 10'd60 || cc[0] !== 3'b000 || ce[0] !== 1'b1 ||
        cx[16] !== 10'd61 || cy[16] !== 10'd60 || cc[16] !== 3'b111) begin
      failures++;
      $display("FAIL b2b_second: got e(%0d,%0d)%b en=%b d(%0d,%0d)%b, want e(60,60)000 1 d(61,60)111",
               cx[0], cy[0], cc[0], ce[0], cx[16], cy[16], cc[16]);
    end
    checks++;
    if (cx[31] !== 10'd64 || cy[31] !== 10'd63 || pos_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end: got last (%0d,%0d) rdy=%b, want (64,63) 1", cx[31], cy[31], pos_ready);
    end
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_erase_draw();
    test_same_pos();
    test_clip();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
